// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the SPI burst arbiter (FSM state encoding, SPI byte width)
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, WAIT, GAP} spi_arb_state_t;
  localparam int SPI_BYTE_W = 8;
endpackage

// File: rtl/spi_burst_arbiter_if.sv
// spi_burst_arbiter_if: requester bus + SPI engine signals; master = requesters/engine side, slave = arbiter
interface spi_burst_arbiter_if
  import spi_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LEN_W = 4
);
  logic [N_REQ-1:0] req, grant, tx_take, rx_valid, burst_done;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ*16-1:0] req_limit;
  logic [N_REQ*SPI_BYTE_W-1:0] req_tx_data;
  logic [SPI_BYTE_W-1:0] rx_data, spi_data_in, spi_data_out;
  logic [15:0] spi_limit;
  logic err_timeout, spi_start, spi_done, spi_cs_n;
  modport master (
    output req, req_len, req_limit, req_tx_data, spi_data_out, spi_done,
    input  grant, tx_take, rx_data, rx_valid, burst_done, err_timeout, spi_start, spi_data_in, spi_limit, spi_cs_n
  );
  modport slave (
    input  req, req_len, req_limit, req_tx_data, spi_data_out, spi_done,
    output grant, tx_take, rx_data, rx_valid, burst_done, err_timeout, spi_start, spi_data_in, spi_limit, spi_cs_n
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick; in req_i, rr_ptr_i; out one-hot grant_next_o, any_req_o
module spi_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic [N_REQ-1:0] grant_next_o,
  output logic             any_req_o
);
  always_comb begin
    grant_next_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(rr_ptr_i) + k) % N_REQ]) begin
        grant_next_o = '0;
        grant_next_o[(int'(rr_ptr_i) + k) % N_REQ] = 1'b1;
      end
    end
  end
  assign any_req_o = |req_i;
endmodule

// File: rtl/spi_burst_arbiter.sv
// spi_burst_arbiter: round-robin multi-byte burst arbiter for one SPI byte engine; ports clk, rst, bus (slave: requester bus + engine)
module spi_burst_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input logic clk,
  input logic rst,
  spi_burst_arbiter_if.slave bus
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  spi_arb_state_t state_q, state_d;
  logic [PW-1:0] idx_q, idx_d, rr_q, rr_d, nxt_idx;
  logic [LEN_W-1:0] rem_q, rem_d, len_sel;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0] lim_q, lim_d;
  logic [SPI_BYTE_W-1:0] tx_q, tx_d, rx_q, rx_d, tx_sel;
  logic [N_REQ-1:0] rxv_q, rxv_d, gnt_nxt, idx_oh;
  logic err_q, err_d, any_req, tout, gap_end;
  spi_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req_i(bus.req), .rr_ptr_i(rr_q), .grant_next_o(gnt_nxt), .any_req_o(any_req)
  );
  always_comb begin
    nxt_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (gnt_nxt[i]) nxt_idx = PW'(i);
  end
  assign idx_oh  = N_REQ'(1) << idx_q;
  assign len_sel = bus.req_len[nxt_idx*LEN_W +: LEN_W];
  assign tx_sel  = bus.req_tx_data[idx_q*SPI_BYTE_W +: SPI_BYTE_W];
  assign tout    = state_q == WAIT && !bus.spi_done && tmr_q == TW'(TIMEOUT - 1);
  assign gap_end = state_q == GAP && gap_q == GW'(GAP_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    lim_d   = lim_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    err_d   = err_q;
    rxv_d   = '0;
    tmr_d   = state_q == LOAD ? TW'(1) : tmr_q + TW'(1);
    gap_d   = state_q == GAP ? gap_q + GW'(1) : '0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = CS_SETUP;
        idx_d   = nxt_idx;
        rr_d    = nxt_idx == PW'(N_REQ - 1) ? '0 : nxt_idx + PW'(1);
        rem_d   = len_sel == '0 ? LEN_W'(1) : len_sel;
        lim_d   = bus.req_limit[nxt_idx*16 +: 16];
        err_d   = 1'b0;
      end
      CS_SETUP: state_d = LOAD;
      LOAD: begin
        state_d = WAIT;
        tx_d    = tx_sel;
      end
      WAIT: if (bus.spi_done) begin
        rx_d    = bus.spi_data_out;
        rxv_d   = idx_oh;
        rem_d   = rem_q - LEN_W'(1);
        state_d = rem_q == LEN_W'(1) ? GAP : LOAD;
      end else if (tout) begin
        err_d   = 1'b1;
        state_d = GAP;
      end
      GAP: state_d = gap_end ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      rem_q   <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
      lim_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxv_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
      lim_q   <= lim_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxv_q   <= rxv_d;
      err_q   <= err_d;
    end
  end
  assign bus.grant       = state_q == IDLE ? '0 : idx_oh;
  assign bus.tx_take     = state_q == LOAD ? idx_oh : '0;
  assign bus.spi_start   = state_q == LOAD;
  assign bus.spi_data_in = state_q == LOAD ? tx_sel : tx_q;
  assign bus.spi_limit   = lim_q;
  assign bus.spi_cs_n    = !(state_q inside {CS_SETUP, LOAD, WAIT});
  assign bus.rx_data     = rx_q;
  assign bus.rx_valid    = rxv_q;
  assign bus.burst_done  = gap_end ? idx_oh : '0;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_spi_burst_arbiter.sv
// tb_spi_burst_arbiter: randomized + directed bench with engine model and burst-level reference model
module tb_spi_burst_arbiter;
  import spi_pkg::*;
  localparam int N = 2, LW = 4, GAP = 2, TO = 64;
  logic clk = 1'b0, rst = 1'b1, hang = 1'b0;
  int checks = 0, errors = 0, ndone = 0, nbytes = 0, nrx = 0;
  int cur = 0, rr = 0, exp_len = 0, cyc = 0, t0 = 0, hi = 0, w = 0, e_cnt = 0;
  logic [7:0] tx_mem [N][256];
  logic [7:0] ptr [N];
  logic [7:0] exp_rx [$];
  logic [7:0] e_dat = '0;
  logic [N-1:0] req_p = '0, grant_p = '0;
  logic [N*LW-1:0] len_p = '0;
  logic [N*16-1:0] lim_p = '0;
  logic [15:0] lim_cur = '0;
  logic rst_p = 1'b1, err_p = 1'b0, in_burst = 1'b0, after_done = 1'b0, seen = 1'b0;
  spi_burst_arbiter_if #(.N_REQ(N), .LEN_W(LW)) bus ();
  spi_burst_arbiter #(.N_REQ(N), .LEN_W(LW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] resp(input logic [7:0] b);
    return {b[3:0], b[7:4]} ^ 8'h96;
  endfunction
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int r, input int len, input int lim);
    bus.req_len[r*LW +: LW]   = LW'(len);
    bus.req_limit[r*16 +: 16] = 16'(lim);
  endtask
  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (ndone < target && k < budget) begin
      tick(1);
      k++;
    end
    check("burst_count", ndone, target);
  endtask
  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (nbytes < n && k < budget) begin
      tick(1);
      k++;
    end
    check("byte_wait", nbytes, n);
  endtask
  initial begin
    bus.spi_done = 1'b0;
    bus.spi_data_out = '0;
    forever begin
      @(negedge clk);
      bus.spi_done = 1'b0;
      if (rst) e_cnt = 0;
      else if (bus.spi_start) begin
        e_cnt = hang ? 0 : 8 * int'(bus.spi_limit);
        e_dat = resp(bus.spi_data_in);
      end else if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          bus.spi_done = 1'b1;
          bus.spi_data_out = e_dat;
        end
      end
    end
  end
  initial begin
    for (int r = 0; r < N; r++) begin
      ptr[r] = '0;
      for (int i = 0; i < 256; i++) tx_mem[r][i] = 8'($urandom);
    end
    tx_mem[0][0] = 8'hA5;
    tx_mem[0][1] = 8'h3C;
    tx_mem[0][2] = 8'hFF;
    for (int r = 0; r < N; r++) bus.req_tx_data[r*8 +: 8] = tx_mem[r][0];
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_p) begin
        in_burst = 1'b0;
        after_done = 1'b0;
        rr = 0;
        exp_rx.delete();
      end else begin
        if (after_done) check("grant_drop", bus.grant, 0);
        after_done = 1'b0;
        if (grant_p == '0 && bus.grant != '0) begin
          w = pick(req_p, rr);
          check("grant", bus.grant, w < 0 ? 0 : 1 << w);
          cur = w < 0 ? 0 : w;
          rr = (cur + 1) % N;
          lim_cur = lim_p[cur*16 +: 16];
          exp_len = len_p[cur*LW +: LW] == '0 ? 1 : int'(len_p[cur*LW +: LW]);
          check("limit_latch", bus.spi_limit, lim_cur);
          check("err_clear", bus.err_timeout, 0);
          check("cs_setup", bus.spi_cs_n, 0);
          if (seen) check("cs_gap", hi >= GAP, 1);
          seen = 1'b1;
          in_burst = 1'b1;
          nbytes = 0;
          nrx = 0;
        end
        if (in_burst) check("grant_hold", bus.grant, 1 << cur);
        if (bus.tx_take != '0) begin
          check("tx_take", bus.tx_take, 1 << cur);
          check("spi_start", bus.spi_start, 1);
          check("cs_low", bus.spi_cs_n, 0);
          check("data_in", bus.spi_data_in, tx_mem[cur][ptr[cur]]);
          check("limit_hold", bus.spi_limit, lim_cur);
          if (!hang) exp_rx.push_back(resp(tx_mem[cur][ptr[cur]]));
          ptr[cur]++;
          bus.req_tx_data[cur*8 +: 8] = tx_mem[cur][ptr[cur]];
          nbytes++;
          t0 = cyc;
        end
        if (bus.rx_valid != '0) begin
          check("rx_owner", bus.rx_valid, 1 << cur);
          if (exp_rx.size() == 0) check("rx_extra", bus.rx_valid, 0);
          else check("rx_data", bus.rx_data, exp_rx.pop_front());
          nrx++;
        end
        if (bus.err_timeout && !err_p) check("timeout_cycle", cyc - t0, TO);
        if (bus.burst_done != '0) begin
          check("done_owner", bus.burst_done, in_burst ? 1 << cur : 0);
          check("done_bytes", nbytes, hang ? 1 : exp_len);
          check("done_rx", nrx, hang ? 0 : exp_len);
          check("done_err", bus.err_timeout, hang);
          check("done_cs", bus.spi_cs_n, 1);
          check("gap_len", hi, GAP - 1);
          in_burst = 1'b0;
          after_done = 1'b1;
          ndone++;
        end
      end
      rst_p = rst;
      req_p = bus.req;
      len_p = bus.req_len;
      lim_p = bus.req_limit;
      grant_p = bus.grant;
      err_p = bus.err_timeout;
      hi = bus.spi_cs_n ? hi + 1 : 0;
    end
  end
  initial begin
    bus.req = '0;
    bus.req_len = '0;
    bus.req_limit = '0;
    tick(3);
    check("rst_grant", bus.grant, 0);
    check("rst_take", bus.tx_take, 0);
    check("rst_rxv", bus.rx_valid, 0);
    check("rst_done", bus.burst_done, 0);
    check("rst_rxd", bus.rx_data, 0);
    check("rst_din", bus.spi_data_in, 0);
    check("rst_lim", bus.spi_limit, 0);
    check("rst_cs", bus.spi_cs_n, 1);
    check("rst_err", bus.err_timeout, 0);
    check("rst_start", bus.spi_start, 0);
    rst = 1'b0;
    set_req(0, 3, 4);
    bus.req = 2'b01;
    wait_done(1, 400);
    bus.req = '0;
    set_req(0, 2, 1);
    set_req(1, 2, 1);
    bus.req = 2'b11;
    wait_done(5, 1000);
    bus.req = '0;
    set_req(1, 0, 2);
    bus.req = 2'b10;
    wait_done(6, 300);
    bus.req = '0;
    set_req(0, 5, 3);
    bus.req = 2'b01;
    wait_bytes(2, 300);
    bus.req = '0;
    bus.req_limit[15:0] = 16'd7;
    wait_done(7, 1000);
    hang = 1'b1;
    set_req(0, 3, 2);
    bus.req = 2'b01;
    wait_done(8, 300);
    bus.req = '0;
    hang = 1'b0;
    tick(2);
    check("err_sticky", bus.err_timeout, 1);
    set_req(1, 1, 1);
    bus.req = 2'b10;
    wait_done(9, 200);
    bus.req = '0;
    set_req(0, 4, 4);
    bus.req = 2'b01;
    wait_bytes(2, 400);
    tick(5);
    rst = 1'b1;
    tick(1);
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_cs", bus.spi_cs_n, 1);
    check("mid_rst_done", bus.burst_done, 0);
    rst = 1'b0;
    bus.req = '0;
    tick(10);
    check("mid_rst_nodone", ndone, 9);
    set_req(1, 2, 2);
    bus.req = 2'b10;
    wait_done(10, 300);
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < N; r++) set_req(r, $urandom_range(0, 15), $urandom_range(1, 2));
      bus.req = N'($urandom_range(1, 3));
      wait_done(11 + i, 1500);
    end
    bus.req = '0;
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
